// File: rtl/hms_pkg.sv
// hms_pkg: definitions shared by the hours/minutes/seconds timekeeper, its display driver
// and their benches.
//   mode_e        timekeeper edit-state codes (RUN, HB, MB, SB, PL)
//   DIGITS        number of scanned seven-segment digits
//   SEG_*         active-low {g,f,e,d,c,b,a} patterns for 0-9, dash and blank
//   CODE_DASH     digit code that the decoder renders as a dash
//   to_bcd()      binary 0..63 to {tens, units} decimal digits
package hms_pkg;

   typedef enum logic [2:0] {
      ModeRun = 3'b000,
      ModeHb  = 3'b001,
      ModeMb  = 3'b010,
      ModeSb  = 3'b011,
      ModePl  = 3'b100
   } mode_e;

   localparam int unsigned DIGITS = 6;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic [3:0] CODE_DASH = 4'hF;

   // Upper nibble tens, lower nibble units; both fit in 4 bits for inputs below 100.
   function automatic logic [7:0] to_bcd(input logic [5:0] v);
      return {4'(v / 6'd10), 4'(v % 6'd10)};
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational digit-code to active-low segment decoder.
//   code_i  4-bit digit code: 0-9 digits, 4'hF dash, anything else blank
//   seg_o   active-low segments {g,f,e,d,c,b,a}
module seg7_decode
   import hms_pkg::*;
(
   input  logic [3:0] code_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      case (code_i)
         4'd0:      seg_o = SEG_0;
         4'd1:      seg_o = SEG_1;
         4'd2:      seg_o = SEG_2;
         4'd3:      seg_o = SEG_3;
         4'd4:      seg_o = SEG_4;
         4'd5:      seg_o = SEG_5;
         4'd6:      seg_o = SEG_6;
         4'd7:      seg_o = SEG_7;
         4'd8:      seg_o = SEG_8;
         4'd9:      seg_o = SEG_9;
         CODE_DASH: seg_o = SEG_DASH;
         default:   seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/hms_display.sv
// hms_display: six-digit multiplexed common-anode driver for the hh:mm:ss timekeeper.
//   clk, rst        clock; asynchronous active-low reset
//   hrs, min, sec   binary time fields, sampled once per frame at the start of slot 0
//   mode            timekeeper state; the field being edited blinks
//   an              digit enables, active-low (digit 5/4 hrs, 3/2 min, 1/0 sec)
//   seg, dp         active-low segments {g,f,e,d,c,b,a} and decimal point
module hms_display
   import hms_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] hrs,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [2:0] mode,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int unsigned ScanW  = $clog2(SCAN_DIV);
   localparam int unsigned BlinkW = $clog2(BLINK_DIV);
   localparam logic [ScanW-1:0]  ScanLast  = ScanW'(SCAN_DIV - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);
   localparam logic [2:0]        SlotLast  = 3'(DIGITS - 1);

   logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [2:0]        slot_q, slot_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d, blink_eff;
   logic              phase_q, phase_d, phase_eff;
   logic [2:0]        mode_prev_q;
   logic [4:0]        snap_hrs_q;
   logic [5:0]        snap_min_q, snap_sec_q;
   logic [5:0]        an_q, an_d;
   logic [6:0]        seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              scan_wrap, snap_load, mode_chg, blink_wrap;
   logic [5:0]        field_val;
   logic              field_ok;
   logic [7:0]        bcd;
   logic [3:0]        digit_code;
   logic [6:0]        digit_seg;
   logic              blank;

   always_comb begin
      scan_wrap  = (scan_cnt_q == ScanLast);
      scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + ScanW'(1);
      slot_d     = slot_q;
      if (scan_wrap) begin
         slot_d = (slot_q == SlotLast) ? 3'd0 : slot_q + 3'd1;
      end
      snap_load = (slot_q == 3'd0) && (scan_cnt_q == '0);

      // A mode change acts in the cycle it is seen: this cycle already counts as a
      // fresh phase-on cycle with blink count 0, so the new field is visible at once.
      mode_chg    = (mode != mode_prev_q);
      blink_eff   = mode_chg ? '0 : blink_cnt_q;
      phase_eff   = mode_chg | phase_q;
      blink_wrap  = (blink_eff == BlinkLast);
      blink_cnt_d = blink_wrap ? '0 : blink_eff + BlinkW'(1);
      phase_d     = phase_eff ^ blink_wrap;
   end

   // Digit content comes only from the frame snapshot; slot[2:1] selects the field.
   always_comb begin
      case (slot_q[2:1])
         2'b10: begin
            field_val = {1'b0, snap_hrs_q};
            field_ok  = (snap_hrs_q <= 5'd23);
         end
         2'b01: begin
            field_val = snap_min_q;
            field_ok  = (snap_min_q <= 6'd59);
         end
         default: begin
            field_val = snap_sec_q;
            field_ok  = (snap_sec_q <= 6'd59);
         end
      endcase
      bcd        = to_bcd(field_val);
      digit_code = !field_ok ? CODE_DASH : (slot_q[0] ? bcd[7:4] : bcd[3:0]);
   end

   seg7_decode u_seg7_decode (
      .code_i (digit_code),
      .seg_o  (digit_seg)
   );

   always_comb begin
      blank = 1'b0;
      if (!phase_eff) begin
         case (mode)
            ModeHb:  blank = (slot_q[2:1] == 2'b10);
            ModeMb:  blank = (slot_q[2:1] == 2'b01);
            ModeSb:  blank = (slot_q[2:1] == 2'b00);
            ModePl:  blank = 1'b1;
            default: blank = 1'b0;
         endcase
      end

      // Position 0 of every slot is a dark guard cycle against ghosting.
      an_d  = 6'h3F;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
      if ((scan_cnt_q != '0) && !blank) begin
         an_d  = ~(6'd1 << slot_q);
         seg_d = digit_seg;
         dp_d  = !((slot_q == 3'd2) || (slot_q == 3'd4));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt_q  <= '0;
         slot_q      <= 3'd0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
         mode_prev_q <= ModeRun;
         snap_hrs_q  <= '0;
         snap_min_q  <= '0;
         snap_sec_q  <= '0;
         an_q        <= 6'h3F;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         scan_cnt_q  <= scan_cnt_d;
         slot_q      <= slot_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         mode_prev_q <= mode;
         if (snap_load) begin
            snap_hrs_q <= hrs;
            snap_min_q <= min;
            snap_sec_q <= sec;
         end
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_hms_display.sv
module tb_hms_display;

   localparam int SD = 4;
   localparam int BD = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] hrs;
   logic [5:0] min;
   logic [5:0] sec;
   logic [2:0] mode;
   logic [5:0] an;
   logic [6:0] seg;
   logic       dp;

   int n_checks = 0;
   int n_pass   = 0;
   bit model_on = 1'b0;

   logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   hms_display #(
      .SCAN_DIV  (SD),
      .BLINK_DIV (BD)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .hrs  (hrs),
      .min  (min),
      .sec  (sec),
      .mode (mode),
      .an   (an),
      .seg  (seg),
      .dp   (dp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
   endtask

   // Wait (bounded) until digit d is enabled; sampled on the falling edge.
   task automatic wait_digit(input int d, output bit found);
      logic [5:0] target;
      target = ~(6'd1 << d);
      found  = 1'b0;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (an === target) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         n_checks++;
         $display("FAIL wait_digit%0d: an=%h, digit never enabled within 64 cycles", d, an);
      end
   endtask

   // Reference model: everything derived from the cycle number since reset release.
   initial begin : compare
      int n, c0, slot, p, fld, v, lim;
      logic [2:0] mprev, i_mode;
      logic       i_rst, blank, phase_on;
      logic [4:0] i_h, sh;
      logic [5:0] i_m, i_s, sm, ss;
      logic [5:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      n = 0; c0 = 1; mprev = 3'b000; sh = '0; sm = '0; ss = '0;
      forever begin
         @(posedge clk);
         i_rst = rst; i_h = hrs; i_m = min; i_s = sec; i_mode = mode;
         #1;
         if (model_on) begin
            e_an = 6'h3F; e_seg = 7'h7F; e_dp = 1'b1;
            if (!i_rst) begin
               n = 0; c0 = 1; mprev = 3'b000; sh = '0; sm = '0; ss = '0;
            end else begin
               n++;
               if (i_mode != mprev) c0 = n;
               mprev = i_mode;
               slot = ((n - 1) / SD) % 6;
               p    = (n - 1) % SD;
               if (slot == 0 && p == 0) begin
                  sh = i_h; sm = i_m; ss = i_s;
               end
               phase_on = (((n - c0) / BD) % 2) == 0;
               fld   = slot / 2;
               blank = 1'b0;
               if (!phase_on) begin
                  case (i_mode)
                     3'b001:  blank = (fld == 2);
                     3'b010:  blank = (fld == 1);
                     3'b011:  blank = (fld == 0);
                     3'b100:  blank = 1'b1;
                     default: blank = 1'b0;
                  endcase
               end
               if (p != 0 && !blank) begin
                  v     = (fld == 2) ? int'(sh) : (fld == 1) ? int'(sm) : int'(ss);
                  lim   = (fld == 2) ? 23 : 59;
                  e_an  = ~(6'd1 << slot);
                  e_seg = (v > lim) ? 7'h3F : pat[(slot % 2 == 1) ? v / 10 : v % 10];
                  e_dp  = !(slot == 2 || slot == 4);
               end
            end
            chk("model_an", an, e_an);
            chk("model_dp", dp, e_dp);
            if (e_an != 6'h3F) chk("model_seg", seg, e_seg);
         end
      end
   end

   initial begin : stim
      logic [6:0] lit_seg [6];
      logic       lit_dp  [6];
      bit         found;
      lit_seg = '{7'h10, 7'h12, 7'h40, 7'h30, 7'h30, 7'h79};
      lit_dp  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

      rst = 1'b1; hrs = 5'd13; min = 6'd30; sec = 6'd59; mode = 3'b000;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst_an", an, 6'h3F);
      chk("async_rst_seg", seg, 7'h7F);
      chk("async_rst_dp", dp, 1'b1);
      model_on = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;

      @(posedge clk); #1;
      chk("edge1_guard_an", an, 6'h3F);
      repeat (3) begin
         @(posedge clk); #1;
         chk("edge2to4_an", an, 6'b111110);
      end

      // 13:30:59 in RUN, literal digit patterns
      for (int d = 0; d < 6; d++) begin
         wait_digit(d, found);
         if (found) begin
            chk($sformatf("lit_seg_d%0d", d), seg, lit_seg[d]);
            chk($sformatf("lit_dp_d%0d", d), dp, lit_dp[d]);
         end
      end

      // Minutes edit blinks for 256 cycles
      @(negedge clk); mode = 3'b010;
      repeat (256) @(negedge clk);

      // RUN, then SB entered mid blink-off: digit 1 visible on its next slot
      mode = 3'b000;
      repeat (BD + BD / 2) @(negedge clk);
      mode = 3'b011;
      wait_digit(1, found);
      if (found) chk("sb_d1_visible_seg", seg, 7'h12);
      repeat (140) @(negedge clk);

      // Snapshot: change during slot 3 shows up next frame
      mode = 3'b000; sec = 6'd58;
      repeat (30) @(negedge clk);
      wait_digit(3, found);
      sec = 6'd59;
      wait_digit(0, found);
      if (found) chk("snap_next_frame_d0", seg, 7'h10);
      // Change right after the snapshot: the current digit must not tear
      repeat (SD) @(negedge clk);
      wait_digit(0, found);
      sec = 6'd57;
      @(negedge clk);
      chk("snap_hold_an", an, 6'b111110);
      chk("snap_hold_seg", seg, 7'h10);
      repeat (20) @(negedge clk);
      wait_digit(0, found);
      if (found) chk("snap_new_d0", seg, 7'h78);

      // Out-of-range fields show dashes
      hrs = 5'd24; min = 6'd60;
      repeat (30) @(negedge clk);
      for (int d = 2; d < 6; d++) begin
         wait_digit(d, found);
         if (found) chk($sformatf("dash_d%0d", d), seg, 7'h3F);
      end

      hrs = 5'd23; min = 6'd59; sec = 6'd0;
      repeat (50) @(negedge clk);
      mode = 3'b100;
      repeat (150) @(negedge clk);
      mode = 3'b001;
      repeat (150) @(negedge clk);
      mode = 3'b111;
      repeat (100) @(negedge clk);

      // Asynchronous reset mid-run
      #2 rst = 1'b0;
      #1;
      chk("async_rst2_an", an, 6'h3F);
      chk("async_rst2_seg", seg, 7'h7F);
      chk("async_rst2_dp", dp, 1'b1);
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
